// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising checker for the 8-bit Galois LFSR stream (x^8+x^4+x^3+x^2+1)
// Optional LFSR_CHK_BITERR_EN: count mismatching bits instead of mismatching words.
module lfsr_checker #(
   parameter int LOCK_COUNT = 4,
   parameter int LOSS_COUNT = 3,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             res_n,
   input  logic             data_valid,
   input  logic [7:0]       data_in,
   input  logic             clear_count,
   output logic             locked,
   output logic             error_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic [7:0]       expected
);

   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int LW = $clog2(LOSS_COUNT + 1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t           state;
   logic [7:0]       pred;
   logic [MW-1:0]    match_cnt;
   logic [LW-1:0]    miss_cnt;
   logic [3:0]       err_inc;
   logic [CNT_W-1:0] err_base;
   logic [CNT_W:0]   err_sum;
   logic [CNT_W-1:0] err_next;

   function automatic logic [7:0] lfsr_step(input logic [7:0] q);
      return {q[6], q[5], q[4], q[3] ^ q[7], q[2] ^ q[7], q[1] ^ q[7], q[0], q[7]};
   endfunction

`ifdef LFSR_CHK_BITERR_EN
   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 8; i++) c = c + {3'd0, v[i]};
      return c;
   endfunction
`endif

   // Saturating increment; a coincident clear restarts from zero so the new error survives.
   always_comb begin
`ifdef LFSR_CHK_BITERR_EN
      err_inc  = popcount8(data_in ^ pred);
`else
      err_inc  = 4'd1;
`endif
      err_base = clear_count ? '0 : err_count;
      err_sum  = {1'b0, err_base} + (CNT_W + 1)'(err_inc);
      err_next = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
   end

   assign expected = pred;

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state       <= SEARCH;
         pred        <= 8'h00;
         match_cnt   <= '0;
         miss_cnt    <= '0;
         locked      <= 1'b0;
         error_pulse <= 1'b0;
         err_count   <= '0;
      end else begin
         error_pulse <= 1'b0;
         if (clear_count) err_count <= '0;
         if (data_valid) begin
            case (state)
               SEARCH: begin
                  // 0x00 is the LFSR lock-up state and can never seed the predictor.
                  if (data_in != 8'h00) begin
                     pred      <= lfsr_step(data_in);
                     match_cnt <= '0;
                     state     <= VERIFY;
                  end
               end
               VERIFY: begin
                  if (data_in == pred) begin
                     pred <= lfsr_step(pred);
                     if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                        state     <= LOCKED;
                        locked    <= 1'b1;
                        miss_cnt  <= '0;
                        match_cnt <= '0;
                     end else begin
                        match_cnt <= match_cnt + MW'(1);
                     end
                  end else if (data_in != 8'h00) begin
                     pred      <= lfsr_step(data_in);
                     match_cnt <= '0;
                  end else begin
                     state <= SEARCH;
                  end
               end
               LOCKED: begin
                  // Flywheel: the predictor free-runs so isolated errors do not drop lock.
                  pred <= lfsr_step(pred);
                  if (data_in == pred) begin
                     miss_cnt <= '0;
                  end else begin
                     error_pulse <= 1'b1;
                     err_count   <= err_next;
                     if (miss_cnt == LW'(LOSS_COUNT - 1)) begin
                        state    <= SEARCH;
                        locked   <= 1'b0;
                        miss_cnt <= '0;
                     end else begin
                        miss_cnt <= miss_cnt + LW'(1);
                     end
                  end
               end
               default: state <= SEARCH;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - directed self-checking bench for lfsr_checker (default and CNT_W=4 instances)
module tb_lfsr_checker;

   logic        clk;
   logic        res_n;
   logic        data_valid;
   logic [7:0]  data_in;
   logic        clear_count;

   logic        locked;
   logic        error_pulse;
   logic [15:0] err_count;
   logic [7:0]  expected;

   logic        locked_s;
   logic        error_pulse_s;
   logic [3:0]  err_count_s;
   logic [7:0]  expected_s;

   int          n_cmp;
   int          n_bad;
   logic [7:0]  tb_pred;

`ifdef LFSR_CHK_BITERR_EN
   localparam int C5_INC = 8;
`else
   localparam int C5_INC = 1;
`endif

   lfsr_checker dut (
      .clk         (clk),
      .res_n       (res_n),
      .data_valid  (data_valid),
      .data_in     (data_in),
      .clear_count (clear_count),
      .locked      (locked),
      .error_pulse (error_pulse),
      .err_count   (err_count),
      .expected    (expected)
   );

   lfsr_checker #(.CNT_W(4)) dut_s (
      .clk         (clk),
      .res_n       (res_n),
      .data_valid  (data_valid),
      .data_in     (data_in),
      .clear_count (clear_count),
      .locked      (locked_s),
      .error_pulse (error_pulse_s),
      .err_count   (err_count_s),
      .expected    (expected_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] nx(input logic [7:0] q);
      return {q[6], q[5], q[4], q[3] ^ q[7], q[2] ^ q[7], q[1] ^ q[7], q[0], q[7]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] w, input logic clr);
      @(negedge clk);
      data_valid  = 1'b1;
      data_in     = w;
      clear_count = clr;
      @(posedge clk);
      #1;
      data_valid  = 1'b0;
      clear_count = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         data_valid = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      res_n = 1'b0;
      data_valid = 1'b0;
      data_in = 8'h00;
      clear_count = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_locked", locked, 0);
      check("rst_pulse", error_pulse, 0);
      check("rst_count", err_count, 0);
      check("rst_expected", expected, 8'h00);
      @(negedge clk);
      res_n = 1'b1;

      repeat (3) send(8'h00, 1'b0);
      check("zero_search_locked", locked, 0);
      check("zero_search_expected", expected, 8'h00);

      send(8'h01, 1'b0);
      idle(1);
      check("gap_hold_expected", expected, 8'h02);
      send(8'h02, 1'b0);
      idle(2);
      send(8'h04, 1'b0);
      send(8'h08, 1'b0);
      check("pre_lock_locked", locked, 0);
      check("pre_lock_expected", expected, 8'h10);
      send(8'h10, 1'b0);
      check("lock_locked", locked, 1);
      check("lock_expected", expected, 8'h20);

      send(8'h20, 1'b0);
      check("clean_pulse_20", error_pulse, 0);
      send(8'h40, 1'b0);
      idle(1);
      send(8'h80, 1'b0);
      send(8'h1D, 1'b0);
      check("clean_expected_3a", expected, 8'h3A);
      check("clean_pulse_1d", error_pulse, 0);
      check("clean_count", err_count, 0);

      send(8'hC5, 1'b0);
      check("err_pulse", error_pulse, 1);
      check("err_count", err_count, C5_INC);
      check("err_count_s", err_count_s, C5_INC);
      check("err_still_locked", locked, 1);
      check("err_flywheel_expected", expected, 8'h74);
      idle(1);
      check("idle_pulse_low", error_pulse, 0);
      send(8'h74, 1'b0);
      check("flywheel_match_pulse", error_pulse, 0);
      check("flywheel_match_count", err_count, C5_INC);
      check("flywheel_expected", expected, 8'hE8);

      tb_pred = 8'hE8;
      send(tb_pred ^ 8'h01, 1'b1);
      tb_pred = nx(tb_pred);
      check("clr_err_count", err_count, 1);
      check("clr_err_count_s", err_count_s, 1);
      send(tb_pred, 1'b1);
      tb_pred = nx(tb_pred);
      check("clr_clean_count", err_count, 0);

      for (int i = 0; i < 3; i++) begin
         send(tb_pred ^ 8'h01, 1'b0);
         tb_pred = nx(tb_pred);
         check("loss_pulse", error_pulse, 1);
         check("loss_count", err_count, i + 1);
         check("loss_locked", locked, (i < 2) ? 1 : 0);
      end

      send(8'h5A, 1'b0);
      tb_pred = nx(8'h5A);
      for (int i = 0; i < 4; i++) begin
         send(tb_pred, 1'b0);
         tb_pred = nx(tb_pred);
         check("relock_locked", locked, (i == 3) ? 1 : 0);
      end
      check("relock_expected", expected, tb_pred);
      check("relock_count", err_count, 3);

      repeat (14) begin
         send(tb_pred ^ 8'h01, 1'b0);
         tb_pred = nx(tb_pred);
         send(tb_pred, 1'b0);
         tb_pred = nx(tb_pred);
      end
      check("burst_count", err_count, 17);
      check("sat_count_s", err_count_s, 4'hF);
      check("burst_locked", locked, 1);

      @(posedge clk);
      #3;
      res_n = 1'b0;
      #1;
      check("async_rst_locked", locked, 0);
      check("async_rst_pulse", error_pulse, 0);
      check("async_rst_count", err_count, 0);
      check("async_rst_count_s", err_count_s, 0);
      check("async_rst_expected", expected, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
Receive-side companion to the team's 8-bit Galois LFSR generator (polynomial x^8+x^4+x^3+x^2+1).
- Accepts one generator word per valid cycle and self-synchronises its predictor to the incoming stream.
- Declares lock, then flags and counts mismatches.
- Sits at the far end of a link or loopback as a pseudorandom-pattern integrity checker.

Parameters:
LOCK_COUNT, 4, consecutive matching words after seeding required to enter LOCKED (>=1)
LOSS_COUNT, 3, consecutive mismatching words in LOCKED that force return to SEARCH (>=1)
CNT_W, 16, width of the error counter

Ports:
clk  input  1  drives all flops, rising edge
res_n  input  1  asynchronous active-low reset
data_valid  input  1  data_in carries a stream word this cycle
data_in  input  8  received LFSR word
clear_count  input  1  synchronous clear of err_count
locked  output  1  checker synchronised to stream
error_pulse  output  1  one-cycle flag: previous valid word mismatched while LOCKED
err_count  output  CNT_W  saturating error count
expected  output  8  predictor value for the next valid word

Behaviour:
- Step function N(q): n0=q7, n1=q0, n2=q7^q1, n3=q7^q2, n4=q7^q3, n5=q4, n6=q5, n7=q6. Identical to the generator.
- Reset (async, res_n=0): state=SEARCH, pred=0x00, match_cnt=0, miss_cnt=0, locked=0, error_pulse=0, err_count=0, expected=0x00. Takes effect without a clock edge.
- All outputs are registered. expected=pred.
- No state, counter or predictor changes on cycles with data_valid=0. error_pulse is 0 on those cycles.
- SEARCH:
  - valid word w != 0x00: pred<=N(w), match_cnt<=0, go to VERIFY.
  - w == 0x00 (lock-up state): never used as a seed; stay in SEARCH.
- VERIFY:
  - valid w == pred: pred<=N(pred), match_cnt++. When match_cnt reaches LOCK_COUNT, go to LOCKED, locked<=1, miss_cnt<=0.
  - valid w != pred, w != 0: reseed, pred<=N(w), match_cnt<=0, stay in VERIFY.
  - valid w != pred, w == 0: go to SEARCH.
  - No errors are counted in VERIFY.
- LOCKED (flywheel):
  - pred<=N(pred) on every valid word, regardless of match.
  - match: miss_cnt<=0.
  - mismatch: error_pulse<=1 next cycle, err_count increments (saturating at all-ones, never wraps), miss_cnt++.
  - When miss_cnt reaches LOSS_COUNT: go to SEARCH, locked<=0 on that same edge. The error for that word is still counted and pulsed.
- Latency: the lock decision and error_pulse are visible one cycle after the deciding word is sampled.
- clear_count=1:
  - err_count<=0 if there is no error that cycle.
  - If an error occurs in the same cycle, err_count<=increment amount (the new error is not lost).
  - No effect on state.

Optional Feature:
Macro LFSR_CHK_BITERR_EN.
- Defined: each LOCKED mismatch adds popcount(data_in ^ pred) (1..8) to err_count, saturating. clear_count with a simultaneous error loads that popcount.
- Not defined: each mismatching word adds exactly 1.
- State machine, lock/loss rules and error_pulse are identical in both builds.

Test Plan:
1. Assert res_n=0 mid-stream with no clock edges -> locked=0, error_pulse=0, err_count=0, expected=0x00 immediately.
2. Consecutive valid words 0x01,0x02,0x04,0x08,0x10 -> locked=1 the cycle after 0x10, expected=0x20. Continue with 0x20,0x40,0x80,0x1D,0x3A -> no error_pulse.
3. While locked (expected=0x3A), send 0xC5 -> error_pulse one cycle, err_count=1 (8 with LFSR_CHK_BITERR_EN), locked stays 1. Next word 0x74 matches (flywheel).
4. Locked, send three consecutive wrong words -> three error_pulses, err_count +3, locked falls after the third. Clean stream seed+4 words -> relock.
5. Random data_valid gaps during steps 2-3 -> identical lock timing in valid-word terms; no advance on invalid cycles. clear_count coincident with an error -> err_count=1.
6. Stream of 0x00 words in SEARCH -> remains SEARCH, locked=0. Error burst with CNT_W=4 -> err_count holds at 0xF.
